// File: rtl/gnrl_iq_pkg.sv
// ============================================================================
// Module      : gnrl_iq_pkg
// Description : Shared types and default widths for the IQ interpolator slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gnrl_iq_pkg;

    localparam int c_DATA_WIDTH = 32;
    localparam int c_INT_WIDTH  = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [c_DATA_WIDTH-1:0] i;
        logic [c_DATA_WIDTH-1:0] q;
    } iq_pair_t;

endpackage

`default_nettype wire

// File: rtl/gnrl_iq_interpolator_if.sv
// ============================================================================
// Module      : gnrl_iq_interpolator_if
// Description : Input/output IQ streams and control of the interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gnrl_iq_interpolator_if
    import gnrl_iq_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int INT_WIDTH  = c_INT_WIDTH
);

    logic [DATA_WIDTH-1:0] dataI;
    logic [DATA_WIDTH-1:0] dataQ;
    logic                  in_valid;
    logic                  in_ready;
    logic [INT_WIDTH-1:0]  int_sel;
    logic [DATA_WIDTH-1:0] dataoutI;
    logic [DATA_WIDTH-1:0] dataoutQ;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_first;
    logic                  underrun;

    modport slave (
        input  dataI, dataQ, in_valid, int_sel, out_ready,
        output in_ready, dataoutI, dataoutQ, out_valid, out_first, underrun
    );

    modport master (
        output dataI, dataQ, in_valid, int_sel, out_ready,
        input  in_ready, dataoutI, dataoutQ, out_valid, out_first, underrun
    );

endinterface

`default_nettype wire

// File: rtl/gnrl_iq_skid_buf.sv
// ============================================================================
// Module      : gnrl_iq_skid_buf
// Description : Two-entry holding/pending buffer for the IQ interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gnrl_iq_skid_buf #(
    parameter int WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_in_ready,
    output logic                  o_load,
    output logic [WIDTH-1:0]      o_hold_data
);

    logic [WIDTH-1:0] r_hold_data;
    logic [WIDTH-1:0] r_pend_data;
    logic             r_hold_full;
    logic             r_pend_full;
    logic             w_load;
    logic             w_from_pend;

    // Holding refills when vacated (pop) or empty; pending has priority over a same-edge push.
    assign w_from_pend = i_pop & r_pend_full;
    assign w_load      = (i_pop & (r_pend_full | i_push)) | (i_push & ~r_hold_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_data <= '0;
            r_pend_data <= '0;
            r_hold_full <= 1'b0;
            r_pend_full <= 1'b0;
        end else begin
            if (w_load) begin
                r_hold_data <= w_from_pend ? r_pend_data : i_data;
                r_hold_full <= 1'b1;
            end else if (i_pop) begin
                r_hold_full <= 1'b0;
            end

            if (w_from_pend) begin
                r_pend_full <= 1'b0;
            end else if (i_push && !w_load) begin
                r_pend_data <= i_data;
                r_pend_full <= 1'b1;
            end
        end
    end

    assign o_in_ready  = rst_n & ~r_pend_full;
    assign o_load      = w_load;
    assign o_hold_data = r_hold_data;

endmodule

`default_nettype wire

// File: rtl/gnrl_iq_interpolator.sv
// ============================================================================
// Module      : gnrl_iq_interpolator
// Description : Sample-and-hold IQ interpolator, repeats each pair int_sel times.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gnrl_iq_interpolator
    import gnrl_iq_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int INT_WIDTH  = c_INT_WIDTH
) (
    input  wire logic              CLK,
    input  wire logic              RESET,
    gnrl_iq_interpolator_if.slave  bus
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [INT_WIDTH-1:0]    r_cnt;
    logic                    r_first;
    logic                    r_underrun;
    logic                    r_emitted;
    logic                    w_out_valid;
    logic                    w_in_ready;
    logic                    w_push;
    logic                    w_xfer;
    logic                    w_last;
    logic                    w_load;
    logic [INT_WIDTH-1:0]    w_sel_m1;
    logic [2*DATA_WIDTH-1:0] w_hold_data;

    assign w_push   = bus.in_valid & w_in_ready;
    assign w_xfer   = w_out_valid & bus.out_ready;
    assign w_last   = w_xfer & (r_cnt == '0);
    assign w_sel_m1 = (bus.int_sel == '0) ? '0 : bus.int_sel - INT_WIDTH'(1);

    gnrl_iq_skid_buf #(
        .WIDTH (2*DATA_WIDTH)
    ) u_skid_buf (
        .clk         (CLK),
        .rst_n       (RESET),
        .i_push      (w_push),
        .i_pop       (w_last),
        .i_data      ({bus.dataI, bus.dataQ}),
        .o_in_ready  (w_in_ready),
        .o_load      (w_load),
        .o_hold_data (w_hold_data)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_nxt = EMIT;
            EMIT:    if (w_last && !w_load) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_out_valid = 1'b0;
        case (r_state)
            EMIT:    w_out_valid = 1'b1;
            default: w_out_valid = 1'b0;
        endcase
    end

    // int_sel is captured only when a pair enters holding, so a held pair keeps its factor.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_underrun <= 1'b0;
            r_emitted  <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt   <= w_sel_m1;
                r_first <= 1'b1;
            end else if (w_xfer) begin
                r_first <= 1'b0;
                if (r_cnt != '0) r_cnt <= r_cnt - INT_WIDTH'(1);
            end

            if (w_xfer) r_emitted <= 1'b1;
            if (r_state == IDLE && bus.out_ready && r_emitted) r_underrun <= 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_first = r_first;
    assign bus.underrun  = r_underrun;
    assign bus.dataoutI  = w_hold_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign bus.dataoutQ  = w_hold_data[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_gnrl_iq_interpolator.sv
// ============================================================================
// Module      : tb_gnrl_iq_interpolator
// Description : Self-checking bench for gnrl_iq_interpolator against a pair/copy model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gnrl_iq_interpolator;
    import gnrl_iq_pkg::*;

    logic CLK;
    logic RESET;
    int   checks;
    int   failures;

    gnrl_iq_interpolator_if bus ();

    gnrl_iq_interpolator dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: the pair being emitted, copies done/total, and a queue of waiting pairs.
    iq_pair_t m_pend[$];
    iq_pair_t m_cur;
    bit       m_held;
    int       m_done;
    int       m_total;
    bit       m_any;
    bit       m_und;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pend.delete();
        m_held = 1'b0;
        m_done = 0;
        m_total = 0;
        m_any = 1'b0;
        m_und = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one clock.
    task automatic tick();
        bit       acc;
        bit       xf;
        iq_pair_t in_pair;
        #1;
        acc = bus.in_valid && bus.in_ready;
        xf  = bus.out_valid && bus.out_ready;
        in_pair.i = bus.dataI;
        in_pair.q = bus.dataQ;
        check("out_valid", 64'(bus.out_valid), 64'(m_held));
        check("in_ready", 64'(bus.in_ready), 64'(m_pend.size() == 0));
        check("underrun", 64'(bus.underrun), 64'(m_und));
        if (m_held) begin
            check("dataoutI", 64'(bus.dataoutI), 64'(m_cur.i));
            check("dataoutQ", 64'(bus.dataoutQ), 64'(m_cur.q));
            check("out_first", 64'(bus.out_first), 64'(m_done == 0));
        end
        @(posedge CLK);
        if (!m_held && bus.out_ready && m_any) m_und = 1'b1;
        if (xf) begin
            m_any = 1'b1;
            m_done++;
            if (m_done == m_total) m_held = 1'b0;
        end
        if (acc) m_pend.push_back(in_pair);
        if (!m_held && m_pend.size() > 0) begin
            m_cur   = m_pend.pop_front();
            m_held  = 1'b1;
            m_done  = 0;
            m_total = (bus.int_sel == 0) ? 1 : int'(bus.int_sel);
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        #1;
        check("rst_dataoutI", 64'(bus.dataoutI), 64'h0);
        check("rst_dataoutQ", 64'(bus.dataoutQ), 64'h0);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_out_first", 64'(bus.out_first), 64'h0);
        check("rst_underrun", 64'(bus.underrun), 64'h0);
        check("rst_in_ready", 64'(bus.in_ready), 64'h0);
        model_clear();
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic drive(input bit v, input int unsigned i, input int unsigned q);
        bus.in_valid = v;
        bus.dataI    = i;
        bus.dataQ    = q;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b0;
        drive(1'b0, 0, 0);
        bus.int_sel   = 16'd3;
        bus.out_ready = 1'b0;
        model_clear();
        @(negedge CLK);

        // Single pair repeated 3 times, then underrun with out_ready held high
        do_reset();
        bus.out_ready = 1'b1;
        drive(1'b1, 100, 200);
        tick();
        drive(1'b0, 0, 0);
        for (int k = 0; k < 6; k++) tick();

        // int_sel = 0 behaves as 1, back-to-back stream
        do_reset();
        bus.int_sel = 16'd0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 11 + k, 21 + k);
            tick();
        end
        drive(1'b0, 0, 0);
        for (int k = 0; k < 3; k++) tick();

        // Backpressure: outputs stall, pending fills, no loss or extra copies
        do_reset();
        bus.int_sel = 16'd2;
        drive(1'b1, 31, 41);
        tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 50 + k, 60 + k);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 70 + k, 80 + k);
            tick();
        end
        drive(1'b0, 0, 0);
        for (int k = 0; k < 12; k++) tick();

        // int_sel changes while a pair is held; next pair uses the new factor
        do_reset();
        bus.int_sel = 16'd4;
        drive(1'b1, 1, 2);
        tick();
        drive(1'b1, 3, 4);
        tick();
        drive(1'b0, 0, 0);
        bus.int_sel = 16'd2;
        for (int k = 0; k < 8; k++) tick();

        // Reset mid-stream during copy 2 of 5, then a clean pair
        do_reset();
        bus.int_sel = 16'd5;
        drive(1'b1, 5, 6);
        tick();
        drive(1'b0, 0, 0);
        tick();
        do_reset();
        drive(1'b1, 7, 9);
        tick();
        drive(1'b0, 0, 0);
        for (int k = 0; k < 7; k++) tick();

        // Random traffic with int_sel = 3
        do_reset();
        bus.int_sel = 16'd3;
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom % 2), $urandom % 8000, $urandom % 8000);
            bus.out_ready = 1'($urandom % 2);
            tick();
        end
        drive(1'b0, 0, 0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
